// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants and the writeback request record.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  // One writeback request: destination register and the value to write.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/riscv_rr_arbiter.sv
// Generic N-way round-robin arbiter: one-hot grant, pointer moves past each winner.
// Latency: grant is combinational from req_i; pointer updates on the granting edge.
// Backpressure: hold_i (or reset) suppresses every grant and freezes the pointer.
module riscv_rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         hold_i,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;
  logic [PTR_W-1:0] win_idx;
  logic             win_any;
  logic             grant_ok;

  // Find the first requester at or after the pointer, wrapping around.
  always_comb begin
    win_any = 1'b0;
    win_idx = '0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!win_any && req_i[i] && (i == ((int'(ptr_q) + k) % N))) begin
          win_any = 1'b1;
          win_idx = PTR_W'(i);
        end
      end
    end
  end

  // A grant is only issued outside reset and while not held.
  assign grant_ok = win_any && !hold_i && rst_n_i;

  // Decode the winning index into a one-hot grant and compute the next pointer.
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    for (int i = 0; i < N; i++) begin
      gnt_o[i] = grant_ok && (win_idx == PTR_W'(i));
    end
    if (grant_ok) begin
      ptr_d = (win_idx == PTR_W'(N - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  a_gnt_onehot: assert property (@(posedge clk_i) disable iff (!rst_n_i) $onehot0(gnt_o));

endmodule

// File: rtl/riscv_wb_arbiter.sv
// Shares the regfile write port among NUM_REQ writeback sources (round-robin) with an optional busy scoreboard.
// Latency: ready is combinational from valid; rf write appears one cycle after the handshake.
// Backpressure: hold_in stalls all requesters; otherwise one write per cycle is sustained. Scoreboard: RISCV_WB_SCOREBOARD_EN.
module riscv_wb_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
  input  logic                          clk_in,
  input  logic                          rst_n_in,
  input  logic                          hold_in,
  input  logic [NUM_REQ-1:0]            req_valid_in,
  output logic [NUM_REQ-1:0]            req_ready_out,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_rd_in,
  input  logic [NUM_REQ*XLEN-1:0]       req_data_in,
  input  logic                          issue_valid_in,
  input  logic [REG_ADDR_W-1:0]         issue_rd_in,
  output logic [2**REG_ADDR_W-1:0]      busy_mask_out,
  output logic                          rf_we_out,
  output logic [REG_ADDR_W-1:0]         rf_rd_out,
  output logic [XLEN-1:0]               rf_wd_out
);

  import riscv_pkg::*;

  localparam int NREGS = 2 ** REG_ADDR_W;

  logic [NUM_REQ-1:0]    gnt;
  logic                  gnt_vld;
  logic [REG_ADDR_W-1:0] sel_rd;
  logic [XLEN-1:0]       sel_wd;

  logic                  we_q, we_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0]       wd_q, wd_d;

  riscv_rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arb (
    .clk_i   (clk_in),
    .rst_n_i (rst_n_in),
    .hold_i  (hold_in),
    .req_i   (req_valid_in),
    .gnt_o   (gnt)
  );

  assign req_ready_out = gnt;
  assign gnt_vld       = |gnt;

  // One-hot mux of the granted requester's destination and data.
  always_comb begin
    sel_rd = '0;
    sel_wd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_rd = req_rd_in[i*REG_ADDR_W +: REG_ADDR_W];
        sel_wd = req_data_in[i*XLEN +: XLEN];
      end
    end
  end

  // Write stage next state: capture on grant, x0 writes are swallowed, idle keeps address/data.
  always_comb begin
    we_d = 1'b0;
    rd_d = rd_q;
    wd_d = wd_q;
    if (gnt_vld) begin
      rd_d = sel_rd;
      wd_d = sel_wd;
      we_d = (sel_rd != '0);
    end
  end

  // Write stage registers driving the regfile port.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      we_q <= 1'b0;
      rd_q <= '0;
      wd_q <= '0;
    end else begin
      we_q <= we_d;
      rd_q <= rd_d;
      wd_q <= wd_d;
    end
  end

  assign rf_we_out = we_q;
  assign rf_rd_out = rd_q;
  assign rf_wd_out = wd_q;

`ifdef RISCV_WB_SCOREBOARD_EN
  logic [NREGS-1:0] busy_q, busy_d;

  // Scoreboard next state: clear on the completing write, then a same-edge issue re-sets (newer wins).
  always_comb begin
    busy_d = busy_q;
    if (we_q) begin
      busy_d[rd_q] = 1'b0;
    end
    if (issue_valid_in && (issue_rd_in != '0)) begin
      busy_d[issue_rd_in] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register; reset drops every in-flight marker.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_mask_out = busy_q;
`else
  logic unused_issue;
  assign unused_issue  = ^{issue_valid_in, issue_rd_in};
  assign busy_mask_out = '0;
`endif

  a_no_x0_write: assert property (@(posedge clk_in) disable iff (!rst_n_in) rf_we_out |-> (rf_rd_out != '0));

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Self-checking bench for riscv_wb_arbiter: directed scenarios followed by random traffic.
// Latency: outputs checked on the falling edge against a behavioural model of the edge rules.
// Backpressure: hold_in exercised both directed and randomly.
module tb_riscv_wb_arbiter;

  localparam int NREQ = 2;
  localparam int XL   = 32;
  localparam int RW   = 5;
`ifdef RISCV_WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 hold;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*RW-1:0]   req_rd;
  logic [NREQ*XL-1:0]   req_data;
  logic                 issue_valid;
  logic [RW-1:0]        issue_rd;
  logic [2**RW-1:0]     busy_mask;
  logic                 rf_we;
  logic [RW-1:0]        rf_rd;
  logic [XL-1:0]        rf_wd;

  riscv_wb_arbiter #(
    .NUM_REQ    (NREQ),
    .XLEN       (XL),
    .REG_ADDR_W (RW)
  ) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .hold_in        (hold),
    .req_valid_in   (req_valid),
    .req_ready_out  (req_ready),
    .req_rd_in      (req_rd),
    .req_data_in    (req_data),
    .issue_valid_in (issue_valid),
    .issue_rd_in    (issue_rd),
    .busy_mask_out  (busy_mask),
    .rf_we_out      (rf_we),
    .rf_rd_out      (rf_rd),
    .rf_wd_out      (rf_wd)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model state: what the regfile port and scoreboard should show now.
  int                 m_ptr;
  bit                 m_we;
  logic [RW-1:0]      m_rd;
  logic [XL-1:0]      m_wd;
  logic [2**RW-1:0]   m_busy;
  logic [NREQ-1:0]    obs_rdy;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr  = 0;
    m_we   = 1'b0;
    m_rd   = '0;
    m_wd   = '0;
    m_busy = '0;
  endtask

  // Winner = valid requester with the smallest circular distance from the pointer.
  function automatic int model_grant();
    int best  = -1;
    int bestd = NREQ;
    if (hold) return -1;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        int d;
        d = (i - m_ptr + NREQ) % NREQ;
        if (d < bestd) begin
          bestd = d;
          best  = i;
        end
      end
    end
    return best;
  endfunction

  task automatic set_req(input int i, input bit v, input logic [RW-1:0] rd, input logic [XL-1:0] dat);
    req_valid[i]         = v;
    req_rd[i*RW +: RW]   = rd;
    req_data[i*XL +: XL] = dat;
  endtask

  // One clock: check everything on the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    int g;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    g = model_grant();
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    obs_rdy = req_ready;
    chk("ready", req_ready, exp_rdy);
    chk("rf_we", rf_we, m_we);
    chk("rf_rd", rf_rd, m_rd);
    chk("rf_wd", rf_wd, m_wd);
    chk("busy", busy_mask, SB ? m_busy : '0);
    if (m_we) m_busy[m_rd] = 1'b0;
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    m_busy[0] = 1'b0;
    if (g >= 0) begin
      m_ptr = (g + 1) % NREQ;
      m_rd  = req_rd[g*RW +: RW];
      m_wd  = req_data[g*XL +: XL];
      m_we  = (req_rd[g*RW +: RW] != 0);
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hold        = 1'b0;
    req_valid   = '0;
    req_rd      = '0;
    req_data    = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
  endtask

  logic [NREQ-1:0] exp_seq [4];

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    req_valid = 2'b11;
    model_reset();
    #2;
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_we", rf_we, 1'b0);
    chk("rst_rd", rf_rd, 5'd0);
    chk("rst_wd", rf_wd, 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    req_valid = '0;
    #1;
    rst_n = 1'b1;
    cycle();

    // Single request with same-cycle ready and one-cycle write latency.
    set_req(0, 1'b1, 5'd5, 32'hDEADBEEF);
    cycle();
    chk("t2_ready", obs_rdy, 2'b01);
    chk("t2_we", rf_we, 1'b1);
    chk("t2_rd", rf_rd, 5'd5);
    chk("t2_wd", rf_wd, 32'hDEADBEEF);
    idle_inputs();

    // x0 write: accepted, no regfile write, pointer moves on.
    set_req(1, 1'b1, 5'd0, 32'h1234);
    cycle();
    chk("t4_ready", obs_rdy, 2'b10);
    chk("t4_we", rf_we, 1'b0);
    idle_inputs();

    // Contention from pointer 0: alternate grants.
    exp_seq = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int c = 0; c < 4; c++) begin
      set_req(0, 1'b1, RW'(c + 1), $urandom);
      set_req(1, 1'b1, RW'(c + 10), $urandom);
      cycle();
      chk("t3_order", obs_rdy, exp_seq[c]);
      chk("t3_rd", rf_rd, (c % 2 == 0) ? RW'(c + 1) : RW'(c + 10));
    end

    // Hold freezes grants and the pointer.
    hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      chk("t6_ready", obs_rdy, 2'b00);
    end
    chk("t6_we", rf_we, 1'b0);
    hold = 1'b0;
    cycle();
    chk("t6_resume", obs_rdy, 2'b01);
    idle_inputs();

    // Scoreboard set, clear after the write cycle, and set-wins on the clearing edge.
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    cycle();
    chk("t5_set", busy_mask[7], SB);
    idle_inputs();
    set_req(0, 1'b1, 5'd7, 32'hA5A5_0007);
    cycle();
    chk("t5_hold_busy", busy_mask[7], SB);
    idle_inputs();
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    cycle();
    chk("t5_set_wins", busy_mask[7], SB);
    idle_inputs();
    set_req(0, 1'b1, 5'd7, 32'h0000_0077);
    cycle();
    idle_inputs();
    cycle();
    chk("t5_cleared", busy_mask[7], 1'b0);

    // Reset in the middle of a write discards the staged write and busy bits at once.
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    set_req(1, 1'b1, 5'd9, 32'hCAFE_0009);
    cycle();
    chk("rst_pre_we", rf_we, 1'b1);
    req_valid = 2'b11;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we", rf_we, 1'b0);
    chk("rst_mid_busy", busy_mask, 32'd0);
    chk("rst_mid_ready", req_ready, 2'b00);
    chk("rst_mid_wd", rf_wd, 32'd0);
    model_reset();
    idle_inputs();
    #1;
    rst_n = 1'b1;
    cycle();

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      hold        = ($urandom_range(0, 9) == 0);
      issue_valid = $urandom_range(0, 1) == 1;
      issue_rd    = RW'($urandom_range(0, 7));
      for (int i = 0; i < NREQ; i++) begin
        set_req(i, $urandom_range(0, 2) != 0, RW'($urandom_range(0, 7)), $urandom);
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
